// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: nibble width,
// FSM state encoding and the signed-overflow helper.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement overflow: operands agree in sign, sum disagrees.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_shreg.sv
// nsa_shreg: W-bit register with parallel load and a 4-bit right shift.
// The serial nibble enters at the top.
module nsa_shreg
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [W-1:0]        load_val,
    input  logic                shift,
    input  logic [NIBBLE_W-1:0] nib_in,
    output logic [W-1:0]        q
);

    // Load has priority over shift; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {nib_in, q[W-1:NIBBLE_W]};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: feeds wide operands to an external 4-bit adder one
// nibble per clock (LSB first), chains the carry and gathers a registered sum.
// Optional feature macro: NSA_OVERFLOW_EN adds the res_ovf output.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   op_b,
    input  logic                          op_cin,
    output logic [NIBBLE_W-1:0]           add_a,
    output logic [NIBBLE_W-1:0]           add_b,
    output logic                          add_cin,
    input  logic [NIBBLE_W-1:0]           add_sum,
    input  logic                          add_cout,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   result,
    output logic                          res_cout
`ifdef NSA_OVERFLOW_EN
    ,
    output logic                          res_ovf
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [W-1:0]       a_q_s;
    logic [W-1:0]       b_q_s;
    logic [W-1:0]       acc_q_s;
    logic               accept_s;
    logic               run_s;
    logic               last_s;

    assign run_s    = (state_r == ST_RUN);
    assign accept_s = in_valid && (state_r == ST_IDLE);
    assign last_s   = run_s && (idx_r == IDX_W'(NIBBLES - 1));

    // Only the low nibbles of the operand registers and the upper nibbles of
    // the accumulator are observed directly; fold the rest away.
    logic unused_bits_s;
    assign unused_bits_s = ^{a_q_s[W-1:NIBBLE_W], b_q_s[W-1:NIBBLE_W],
                             acc_q_s[NIBBLE_W-1:0]};

    nsa_shreg #(.W(W)) u_sh_a (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val (op_a),
        .shift    (run_s),
        .nib_in   (4'b0000),
        .q        (a_q_s)
    );

    nsa_shreg #(.W(W)) u_sh_b (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val (op_b),
        .shift    (run_s),
        .nib_in   (4'b0000),
        .q        (b_q_s)
    );

    nsa_shreg #(.W(W)) u_sh_acc (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val ({W{1'b0}}),
        .shift    (run_s),
        .nib_in   (add_sum),
        .q        (acc_q_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and handshake/adder outputs.
    always_comb begin
        state_s   = state_r;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        add_a     = 4'b0000;
        add_b     = 4'b0000;
        add_cin   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                add_a   = a_q_s[NIBBLE_W-1:0];
                add_b   = b_q_s[NIBBLE_W-1:0];
                add_cin = carry_r;
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Nibble index and inter-nibble carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r   <= '0;
            carry_r <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= '0;
            carry_r <= op_cin;
        end else if (run_s) begin
            idx_r   <= idx_r + IDX_W'(1);
            carry_r <= add_cout;
        end else begin
            idx_r   <= idx_r;
            carry_r <= carry_r;
        end
    end

    // Result capture on the final nibble so no partial sum is ever visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            res_cout <= 1'b0;
        end else if (last_s) begin
            result   <= {add_sum, acc_q_s[W-1:NIBBLE_W]};
            res_cout <= add_cout;
        end else begin
            result   <= result;
            res_cout <= res_cout;
        end
    end

`ifdef NSA_OVERFLOW_EN
    // Signed overflow from the top operand nibbles and the top sum bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_ovf <= 1'b0;
        end else if (last_s) begin
            res_ovf <= signed_ovf(a_q_s[NIBBLE_W-1], b_q_s[NIBBLE_W-1],
                                  add_sum[NIBBLE_W-1]);
        end else begin
            res_ovf <= res_ovf;
        end
    end
`endif

endmodule
